// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the HI/LO registers.
// One result bit per CALC cycle on operand magnitudes. A final CALC cycle applies the
// sign correction and loads hi/lo.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e               state_q, state_d;
  logic                 op_q, op_d;
  logic                 neg_q, neg_d;          // negate product / quotient
  logic                 neg_rem_q, neg_rem_d;  // negate remainder (dividend sign)
  logic                 dz_q, dz_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       add_sum, sub_diff;
  logic [2*WIDTH-1:0]   mul_step, div_step, prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;
  logic                 last_iter_done;

  // Operand magnitudes and one shift-add / restoring-divide step.
  always_comb begin
    a_neg   = is_signed & src_a[WIDTH-1];
    b_neg   = is_signed & src_b[WIDTH-1];
    mag_a   = a_neg ? -src_a : src_a;
    mag_b   = b_neg ? -src_b : src_b;
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    // Shifted partial remainder minus divisor; bit WIDTH set means it did not fit.
    sub_diff = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};
    mul_step = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    div_step = sub_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                               : {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    prod_fix = neg_q ? -acc_q : acc_q;
    quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    last_iter_done = (cnt_q == CNT_W'(WIDTH));
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic; divide-by-zero spends one CALC cycle, then finishes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StCalc;
      StCalc:   if (dz_q || last_iter_done) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StFinish);
    div_zero = (state_q == StFinish) && dz_q;
  end

  // Datapath next-state: latch on accept, iterate in CALC, load hi/lo on exit.
  always_comb begin
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    cnt_d     = cnt_q;
    b_d       = b_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d      = op;
          dz_d      = op && (src_b == '0);
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          b_d       = mag_b;
          acc_d     = {{WIDTH{1'b0}}, mag_a};
          cnt_d     = '0;
        end
      end
      StCalc: begin
        // hi/lo are left untouched on divide-by-zero.
        if (!dz_q) begin
          if (!last_iter_done) begin
            acc_d = op_q ? div_step : mul_step;
            cnt_d = cnt_q + CNT_W'(1);
          end else if (op_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q      <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      cnt_q     <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      cnt_q     <= cnt_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected results computed with
// plain 64-bit arithmetic; a negedge monitor checks busy/done/div_zero/hi/lo.
module tb_mult_div_unit;
  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           acc_cyc;
    int           done_cyc;
  } exp_t;

  exp_t sb_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .is_signed(is_signed),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one operation (called at posedge+#1) and record the expected response.
  task automatic issue(input logic o, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    exp_t        e;
    longint      sa, sb;
    logic [63:0] r;
    e.dz = 1'b0;
    sa = s ? longint'($signed(a)) : longint'({32'b0, a});
    sb = s ? longint'($signed(b)) : longint'({32'b0, b});
    if (!o) begin
      r = sa * sb;
      m_hi = r[63:32];
      m_lo = r[31:0];
    end else if (b == '0) begin
      e.dz = 1'b1;
    end else begin
      r = sa / sb;
      m_lo = r[31:0];
      r = sa % sb;
      m_hi = r[31:0];
    end
    e.hi = m_hi;
    e.lo = m_lo;
    start = 1'b1; op = o; is_signed = s; src_a = a; src_b = b;
    @(posedge clock); #1;
    start = 1'b0;
    src_a = $urandom; src_b = $urandom; op = $urandom_range(0, 1);
    e.acc_cyc  = cyc;
    e.done_cyc = cyc + (e.dz ? 1 : W + 1);
    sb_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() > 0 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("drain", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  // Monitor: compares every cycle against the scoreboard head.
  always @(negedge clock) begin
    if (mon_en) begin
      logic exp_busy, exp_done;
      exp_busy = (sb_q.size() > 0) && (cyc >= sb_q[0].acc_cyc);
      exp_done = (sb_q.size() > 0) && (cyc == sb_q[0].done_cyc);
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("done", 64'(done), 64'(exp_done));
      chk("div_zero", 64'(div_zero), 64'(exp_done && sb_q[0].dz));
      if (exp_done) begin
        chk("hi", 64'(hi), 64'(sb_q[0].hi));
        chk("lo", 64'(lo), 64'(sb_q[0].lo));
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(posedge clock);
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst dz", 64'(div_zero), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    issue(1'b0, 1'b1, -32'sd3, 32'd5);
    wait_idle();
    chk("mul_s hi", 64'(hi), 64'hFFFFFFFF);
    chk("mul_s lo", 64'(lo), 64'hFFFFFFF1);

    issue(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle();
    chk("mul_u hi", 64'(hi), 64'hFFFFFFFE);
    chk("mul_u lo", 64'(lo), 64'h00000001);

    issue(1'b1, 1'b1, -32'sd7, 32'd2);
    wait_idle();
    chk("div_s lo", 64'(lo), 64'hFFFFFFFD);
    chk("div_s hi", 64'(hi), 64'hFFFFFFFF);

    issue(1'b1, 1'b0, 32'd100, 32'd7);
    wait_idle();
    chk("div_u lo", 64'(lo), 64'h0000000E);
    chk("div_u hi", 64'(hi), 64'h00000002);

    issue(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();
    chk("ovf lo", 64'(lo), 64'h80000000);
    chk("ovf hi", 64'(hi), 64'h0);

    issue(1'b1, 1'b1, 32'd5, 32'd0);
    wait_idle();
    chk("dz hi kept", 64'(hi), 64'h0);
    chk("dz lo kept", 64'(lo), 64'h80000000);

    // start mid-CALC with other operands must be ignored
    issue(1'b0, 1'b0, 32'd1234, 32'd5678);
    repeat (5) begin @(posedge clock); #1; end
    start = 1'b1; op = 1'b1; src_a = 32'd99; src_b = 32'd0;
    @(posedge clock); #1;
    start = 1'b0;
    wait_idle();

    // start held during the FINISH cycle must be ignored
    issue(1'b1, 1'b0, 32'd1000, 32'd3);
    t = cyc + W + 1;
    while (cyc < t) begin @(posedge clock); #1; end
    start = 1'b1; op = 1'b0; src_a = 32'd7; src_b = 32'd9;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    wait_idle();

    // reset at iteration 10 aborts without a done pulse
    issue(1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0);
    repeat (10) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    sb_q.delete();
    m_hi = '0;
    m_lo = '0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    repeat (40) begin @(posedge clock); #1; end

    issue(1'b0, 1'b0, 32'd6, 32'd7);
    wait_idle();
    chk("post-rst lo", 64'(lo), 64'd42);

    for (int i = 0; i < 40; i++) begin
      logic         o, s;
      logic [W-1:0] a, b;
      o = $urandom_range(0, 1);
      s = $urandom_range(0, 1);
      a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 9));
        2:       b = 32'hFFFFFFFF;
        default: b = W'($urandom);
      endcase
      issue(o, s, a, b);
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
